// File: rtl/rld_sched_pkg.sv
// Shared types and default sizing for the RLDRAM read-burst scheduler.
package rld_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int DEF_QUEUE_ID_WIDTH  = 2;
  localparam int DEF_CREDIT_WIDTH    = 5;
  localparam int OUTSTANDING_WIDTH   = 3;
  localparam int DEF_MAX_CREDITS     = 16;
  localparam int DEF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/rld_rr_pick.sv
// Combinational round-robin picker: first eligible queue after last_grant, wrapping.
module rld_rr_pick
  import rld_sched_pkg::*;
#(
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = DEF_QUEUE_ID_WIDTH
) (
  input  logic [NUM_QUEUES-1:0]     eligible,
  input  logic [QUEUE_ID_WIDTH-1:0] last_grant,
  output logic [QUEUE_ID_WIDTH-1:0] pick_id,
  output logic                      pick_valid
);

  logic [QUEUE_ID_WIDTH-1:0] idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    // Offsets 1..NUM_QUEUES so last_grant itself is searched last.
    for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
      idx = QUEUE_ID_WIDTH'((32'(last_grant) + i) % NUM_QUEUES);
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

endmodule

// File: rtl/rld_read_burst_scheduler.sv
// RLDRAM read-burst scheduler: credit/outstanding tracking and round-robin request issue.
module rld_read_burst_scheduler
  import rld_sched_pkg::*;
#(
  parameter int NUM_QUEUES      = 4,
  parameter int QUEUE_ID_WIDTH  = DEF_QUEUE_ID_WIDTH,
  parameter int CREDIT_WIDTH    = DEF_CREDIT_WIDTH,
  parameter int MAX_CREDITS     = DEF_MAX_CREDITS,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int BURST_GAP       = 2
) (
  input  logic                         memclk,
  input  logic                         reset,
  input  logic [NUM_QUEUES-1:0]        mem_queue_empty,
  input  logic [NUM_QUEUES-1:0]        credit_return,
  output logic                         rd_req,
  output logic [QUEUE_ID_WIDTH-1:0]    rd_req_queue_id,
  input  logic                         rd_ack,
  input  logic                         rd_done,
  output logic [NUM_QUEUES-1:0]        burst_inc,
  output logic [OUTSTANDING_WIDTH-1:0] outstanding,
  output logic                         busy,
  output logic                         err
);

  localparam int GAP_W    = (BURST_GAP > 1) ? $clog2(BURST_GAP) : 1;
  localparam int GAP_LOAD = (BURST_GAP > 0) ? BURST_GAP - 1 : 0;
  localparam logic [CREDIT_WIDTH-1:0]      CREDIT_FULL = CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [OUTSTANDING_WIDTH-1:0] OUT_LIMIT   = OUTSTANDING_WIDTH'(MAX_OUTSTANDING);

  sched_state_t              state_q, state_d;
  logic [QUEUE_ID_WIDTH-1:0] id_q, id_d, last_grant_q, pick_id;
  logic                      pick_valid;
  logic [GAP_W-1:0]          gap_cnt_q;
  logic [CREDIT_WIDTH-1:0]   credit_q [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]     eligible, credit_dec, credit_ovf;
  logic                      accept;

  assign rd_req          = (state_q == REQ);
  assign rd_req_queue_id = id_q;
  // Gated by reset so a pending request cannot pulse burst_inc in the reset cycle.
  assign accept          = rd_req && rd_ack && !reset;
  assign busy            = (state_q != IDLE) || (outstanding != '0);

  always_comb begin
    eligible   = '0;
    credit_dec = '0;
    credit_ovf = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      eligible[q]   = !mem_queue_empty[q] && (credit_q[q] != '0) && (outstanding < OUT_LIMIT);
      credit_dec[q] = accept && (id_q == QUEUE_ID_WIDTH'(q));
      credit_ovf[q] = credit_return[q] && !credit_dec[q] && (credit_q[q] == CREDIT_FULL);
    end
  end

  always_comb begin
    burst_inc = '0;
    if (accept) burst_inc[id_q] = 1'b1;
  end

  rld_rr_pick #(
    .NUM_QUEUES     (NUM_QUEUES),
    .QUEUE_ID_WIDTH (QUEUE_ID_WIDTH)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: if (pick_valid) begin
        state_d = REQ;
        id_d    = pick_id;
      end
      REQ:  if (accept) state_d = (BURST_GAP == 0) ? IDLE : GAP;
      GAP:  if (gap_cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge memclk) begin
    if (reset) begin
      state_q      <= IDLE;
      id_q         <= '0;
      last_grant_q <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
      gap_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      if (accept) begin
        last_grant_q <= id_q;
        gap_cnt_q    <= GAP_W'(GAP_LOAD);
      end else if (state_q == GAP) begin
        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      end
    end
  end

  always_ff @(posedge memclk) begin
    if (reset) begin
      for (int unsigned q = 0; q < NUM_QUEUES; q++) credit_q[q] <= CREDIT_FULL;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        if (credit_return[q] && !credit_dec[q] && (credit_q[q] != CREDIT_FULL))
          credit_q[q] <= credit_q[q] + CREDIT_WIDTH'(1);
        else if (credit_dec[q] && !credit_return[q])
          credit_q[q] <= credit_q[q] - CREDIT_WIDTH'(1);
      end
      if (accept && !rd_done)
        outstanding <= outstanding + OUTSTANDING_WIDTH'(1);
      else if (rd_done && !accept && (outstanding != '0))
        outstanding <= outstanding - OUTSTANDING_WIDTH'(1);
      if ((|credit_ovf) || (rd_done && !accept && (outstanding == '0)))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rld_read_burst_scheduler.sv
// Directed self-checking bench for rld_read_burst_scheduler (default parameters).
module tb_rld_read_burst_scheduler;

  logic       memclk = 1'b0;
  logic       reset;
  logic [3:0] mem_queue_empty, credit_return;
  logic       rd_req;
  logic [1:0] rd_req_queue_id;
  logic       rd_ack, rd_done;
  logic [3:0] burst_inc;
  logic [2:0] outstanding;
  logic       busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 memclk = ~memclk;

  rld_read_burst_scheduler #(
    .NUM_QUEUES(4), .QUEUE_ID_WIDTH(2), .CREDIT_WIDTH(5),
    .MAX_CREDITS(16), .MAX_OUTSTANDING(4), .BURST_GAP(2)
  ) dut (
    .memclk(memclk), .reset(reset), .mem_queue_empty(mem_queue_empty),
    .credit_return(credit_return), .rd_req(rd_req), .rd_req_queue_id(rd_req_queue_id),
    .rd_ack(rd_ack), .rd_done(rd_done), .burst_inc(burst_inc),
    .outstanding(outstanding), .busy(busy), .err(err)
  );

  task automatic do_reset();
    reset = 1'b1; mem_queue_empty = '1; credit_return = '0; rd_ack = 1'b0; rd_done = 1'b0;
    repeat (2) @(negedge memclk);
    reset = 1'b0;
  endtask

  // Returns at the negedge where rd_req && rd_ack is seen; the accept lands on the next posedge.
  task automatic wait_accept(input int budget, output bit got, output logic [1:0] id);
    got = 1'b0; id = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge memclk);
      if (rd_req && rd_ack) begin got = 1'b1; id = rd_req_queue_id; break; end
    end
  endtask

  task automatic pulse_done();
    @(negedge memclk); rd_done = 1'b1;
    @(negedge memclk); rd_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
    n_checks++; if (rd_req_queue_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", rd_req_queue_id); end
    n_checks++; if (burst_inc !== 4'b0) begin n_fail++; $display("FAIL reset_burst_inc: got %b expected 0000", burst_inc); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    for (int q = 0; q < 4; q++) begin
      n_checks++; if (dut.credit_q[q] !== 5'd16) begin n_fail++; $display("FAIL reset_credit[%0d]: got %0d expected 16", q, dut.credit_q[q]); end
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int last = 0;
    do_reset();
    mem_queue_empty = '0; rd_ack = 1'b1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge memclk); rd_done = 1'b0;
      if (rd_req && rd_ack) begin
        n_checks++; if (rd_req_queue_id !== 2'(n % 4)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d expected %0d", n, rd_req_queue_id, n % 4); end
        n_checks++; if (burst_inc !== 4'(1 << (n % 4))) begin n_fail++; $display("FAIL rr_burst_inc[%0d]: got %b expected %b", n, burst_inc, 4'(1 << (n % 4))); end
        if (n > 0) begin
          n_checks++; if (c - last != 4) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d expected 4", n, c - last); end
        end
        last = c; n++;
        rd_done = 1'b1;
      end
    end
    @(negedge memclk); rd_done = 1'b0;
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", n); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rr_done_with_accept_outstanding: got %0d expected 0", outstanding); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b expected 0", err); end
  endtask

  task automatic test_outstanding_credit();
    int total = 0;
    bit got;
    logic [1:0] id;
    do_reset();
    mem_queue_empty = 4'b1011; rd_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(10, got, id);
      if (got) total++;
      n_checks++; if (!got || id !== 2'd2) begin n_fail++; $display("FAIL oc_first[%0d]: got accept=%0d id=%0d expected accept=1 id=2", k, got, id); end
    end
    wait_accept(12, got, id);
    n_checks++; if (got) begin n_fail++; $display("FAIL oc_limit: got accept=1 expected none at outstanding limit"); end
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL oc_outstanding4: got %0d expected 4", outstanding); end
    n_checks++; if (dut.credit_q[2] !== 5'd12) begin n_fail++; $display("FAIL oc_credit12: got %0d expected 12", dut.credit_q[2]); end
    for (int k = 0; k < 12; k++) begin
      pulse_done();
      wait_accept(10, got, id);
      if (got) total++;
    end
    @(negedge memclk);
    n_checks++; if (total != 16) begin n_fail++; $display("FAIL oc_total16: got %0d expected 16", total); end
    n_checks++; if (dut.credit_q[2] !== 5'd0) begin n_fail++; $display("FAIL oc_credit0: got %0d expected 0", dut.credit_q[2]); end
    pulse_done();
    wait_accept(12, got, id);
    n_checks++; if (got) begin n_fail++; $display("FAIL oc_credit_stall: got accept=1 expected none at credit 0"); end
    n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL oc_outstanding3: got %0d expected 3", outstanding); end
    @(negedge memclk); credit_return = 4'b0100;
    @(negedge memclk); credit_return = 4'b0000;
    wait_accept(10, got, id);
    if (got) total++;
    n_checks++; if (!got || id !== 2'd2) begin n_fail++; $display("FAIL oc_after_return: got accept=%0d id=%0d expected accept=1 id=2", got, id); end
    @(negedge memclk);
    n_checks++; if (total != 17) begin n_fail++; $display("FAIL oc_total17: got %0d expected 17", total); end
    n_checks++; if (dut.credit_q[2] !== 5'd0 || outstanding !== 3'd4) begin n_fail++; $display("FAIL oc_final: got credit=%0d outstanding=%0d expected 0/4", dut.credit_q[2], outstanding); end
  endtask

  task automatic test_ack_hold();
    do_reset();
    mem_queue_empty = '0; rd_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge memclk);
      if (rd_req) break;
    end
    n_checks++; if (rd_req !== 1'b1 || rd_req_queue_id !== 2'd0) begin n_fail++; $display("FAIL hold_start: got rd_req=%b id=%0d expected 1/0", rd_req, rd_req_queue_id); end
    for (int i = 0; i < 10; i++) begin
      mem_queue_empty = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      @(negedge memclk);
      n_checks++; if ({rd_req, rd_req_queue_id, burst_inc} !== 7'b1_00_0000) begin n_fail++; $display("FAIL hold_cycle[%0d]: got rd_req=%b id=%0d burst_inc=%b expected 1/0/0000", i, rd_req, rd_req_queue_id, burst_inc); end
    end
    rd_ack = 1'b1;
    #1;
    n_checks++; if (burst_inc !== 4'b0001) begin n_fail++; $display("FAIL hold_accept_burst_inc: got %b expected 0001", burst_inc); end
    @(negedge memclk);
    n_checks++; if (rd_req !== 1'b0 || outstanding !== 3'd1) begin n_fail++; $display("FAIL hold_after: got rd_req=%b outstanding=%0d expected 0/1", rd_req, outstanding); end
    n_checks++; if (dut.credit_q[0] !== 5'd15) begin n_fail++; $display("FAIL hold_credit: got %0d expected 15", dut.credit_q[0]); end
  endtask

  task automatic test_simultaneous();
    bit got;
    logic [1:0] id;
    do_reset();
    mem_queue_empty = 4'b1101; rd_ack = 1'b1;
    wait_accept(10, got, id);
    wait_accept(10, got, id);
    n_checks++; if (!got || id !== 2'd1) begin n_fail++; $display("FAIL sim_second_accept: got accept=%0d id=%0d expected 1/1", got, id); end
    credit_return = 4'b0010; rd_done = 1'b1;
    @(negedge memclk); credit_return = '0; rd_done = 1'b0;
    n_checks++; if (dut.credit_q[1] !== 5'd15) begin n_fail++; $display("FAIL sim_credit: got %0d expected 15", dut.credit_q[1]); end
    n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL sim_outstanding: got %0d expected 1", outstanding); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sim_err: got %b expected 0", err); end
  endtask

  task automatic test_errors();
    do_reset();
    @(negedge memclk); credit_return = 4'b0001;
    @(negedge memclk); credit_return = '0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_credit_ovf: got %b expected 1", err); end
    n_checks++; if (dut.credit_q[0] !== 5'd16) begin n_fail++; $display("FAIL err_credit_sat: got %0d expected 16", dut.credit_q[0]); end
    pulse_done();
    n_checks++; if (err !== 1'b1 || outstanding !== 3'd0) begin n_fail++; $display("FAIL err_done_underflow: got err=%b outstanding=%0d expected 1/0", err, outstanding); end
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [1:0] id;
    do_reset();
    @(negedge memclk); credit_return = 4'b1000;
    @(negedge memclk); credit_return = '0;
    mem_queue_empty = '0; rd_ack = 1'b1;
    for (int k = 0; k < 3; k++) wait_accept(10, got, id);
    @(negedge memclk); rd_ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge memclk);
      if (rd_req) break;
    end
    n_checks++; if (rd_req !== 1'b1 || outstanding !== 3'd3 || err !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got rd_req=%b outstanding=%0d err=%b expected 1/3/1", rd_req, outstanding, err); end
    reset = 1'b1; rd_ack = 1'b1;
    #1;
    n_checks++; if (burst_inc !== 4'b0) begin n_fail++; $display("FAIL rst_no_burst_inc: got %b expected 0000", burst_inc); end
    @(negedge memclk);
    n_checks++; if (rd_req !== 1'b0 || outstanding !== 3'd0 || err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_post: got rd_req=%b outstanding=%0d err=%b busy=%b expected 0/0/0/0", rd_req, outstanding, err, busy); end
    for (int q = 0; q < 4; q++) begin
      n_checks++; if (dut.credit_q[q] !== 5'd16) begin n_fail++; $display("FAIL rst_credit[%0d]: got %0d expected 16", q, dut.credit_q[q]); end
    end
    reset = 1'b0; rd_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_outstanding_credit();
    test_ack_hold();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
